demux: RTL and testbench
========================

Name: demux

Overview:
- Receiving-side counterpart of the two-input burst multiplexer. It takes the single merged stream (data plus valid) and splits it back into two lanes.
- Routing is burst-based. One contiguous run of valid words is a burst, and a whole burst goes to one lane. Lanes alternate burst by burst, starting with lane 0, which matches the multiplexer's lane-0-first, alternate-on-gap arbitration.
- Outputs are registered. The block respects per-lane downstream full flags and keeps per-lane word counters.

Parameters:
- DATA_W, 8, width of data words.
- CNT_W, 8, width of the per-lane delivered-word counters.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in_c  input  DATA_W  merged input data.
- valid_in_c  input  1  data_in_c holds a word this cycle.
- full_0_c  input  1  lane 0 downstream cannot accept a word.
- full_1_c  input  1  lane 1 downstream cannot accept a word.
- data_out_0_c  output  DATA_W  lane 0 data, registered.
- valid_out_0_c  output  1  lane 0 word valid, registered.
- data_out_1_c  output  DATA_W  lane 1 data, registered.
- valid_out_1_c  output  1  lane 1 word valid, registered.
- drop_c  output  1  one-cycle pulse: a word was discarded because its lane was full.
- count_0_c  output  CNT_W  words delivered on lane 0, wraps.
- count_1_c  output  CNT_W  words delivered on lane 1, wraps.

Behaviour:
- Reset (reset=1 at a clock edge):
  - State goes to IDLE_NEXT0.
  - All data_out, valid_out, drop_c and count outputs go to 0.
  - Reset has priority over everything. A burst in flight when reset is asserted is abandoned; the word presented in the reset cycle is neither delivered nor counted.
- States: one-hot, four states.
  - IDLE_NEXT0: no burst in progress; the next burst goes to lane 0.
  - IDLE_NEXT1: no burst in progress; the next burst goes to lane 1.
  - ROUTE_0: a burst is in progress on lane 0.
  - ROUTE_1: a burst is in progress on lane 1.
- Transitions, evaluated each edge:
  - IDLE_NEXT0 with valid_in_c=1 goes to ROUTE_0; this word is the burst's first word and goes to lane 0.
  - IDLE_NEXT1 with valid_in_c=1 goes to ROUTE_1; this word goes to lane 1.
  - ROUTE_0 with valid_in_c=1 stays in ROUTE_0. With valid_in_c=0 it goes to IDLE_NEXT1.
  - ROUTE_1 with valid_in_c=1 stays in ROUTE_1. With valid_in_c=0 it goes to IDLE_NEXT0.
  - Idle states with valid_in_c=0 hold.
  - A single idle cycle ends a burst. Back-to-back bursts therefore need at least one gap cycle.
- Data path:
  - A word accepted at edge N appears on its lane's data_out/valid_out during cycle N+1, giving 1-cycle latency.
  - The non-selected lane has valid_out=0 and data_out=0. A lane's data_out is 0 whenever its valid_out=0.
- Backpressure: the destination lane's full flag is sampled in the same cycle as the word.
  - If full, the word is dropped: that lane's valid_out stays 0, drop_c=1 in cycle N+1, and the count is unchanged.
  - A dropped word does not end the burst. State follows valid_in_c only.
  - The full flag of the non-destination lane is ignored.
- Counters:
  - count_x_c increments by 1 in cycle N+1 for each word delivered on lane x.
  - It wraps from 2^CNT_W-1 to 0 with no flag.
  - Both counters can never change in the same cycle.
- There is no input handshake back to the source: valid_in_c is never stalled.

Optional Feature:
- Macro: DEMUX_TAG_ROUTE_EN.
- Defined:
  - The first word of each burst selects the lane from data_in_c[DATA_W-1]: 0 selects lane 0, 1 selects lane 1.
  - The rest of the burst follows that first word regardless of later tag bits.
  - The tag bit is forwarded unchanged.
  - IDLE_NEXT0 and IDLE_NEXT1 both behave as a single idle state, and alternation is disabled.
  - Drop and counter rules are unchanged.
- Not defined: pure burst alternation as described in Behaviour.

Test Plan:
- Reset, then a burst of 0x11,0x22,0x33 with valid=1 for 3 cycles, then 1 idle cycle -> lane 0 outputs 0x11,0x22,0x33 in cycles 2-4; lane 1 valid=0 throughout; count_0_c=3; state IDLE_NEXT1.
- Burst 0xA0,0xA1, gap, burst 0xB0, gap, burst 0xC0 -> 0xA0,0xA1 on lane 0; 0xB0 on lane 1; 0xC0 on lane 0; count_0_c=3, count_1_c=1.
- Lane 0 burst 0x01,0x02,0x03 with full_0_c=1 only during 0x02 -> lane 0 delivers 0x01 then 0x03; drop_c pulses once, one cycle after 0x02 is presented; count_0_c=2; full_1_c toggling has no effect.
- reset asserted mid-burst on the 2nd of 4 words (0x55) -> the cycle after reset all outputs are 0; remaining words 0x66,0x77 are treated as a new burst on lane 0 and count_0_c=2.
- 256 single-word bursts with gaps -> count_0_c and count_1_c each reach 128 with no drops; then 128 more lane-0 words wrap count_0_c to 0.
- DEMUX_TAG_ROUTE_EN defined: bursts 0x85,0x05 then gap then 0x07 -> both words of the first burst (0x85 then 0x05) go to lane 1; 0x07 goes to lane 0.

Source files
------------

// File: rtl/demux.sv
// Burst demultiplexer: splits a merged valid/data stream into two registered lanes, one burst per lane.
// Optional DEMUX_TAG_ROUTE_EN: the MSB of a burst's first word picks the lane instead of alternation.
module demux #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in_c,
  input  logic              valid_in_c,
  input  logic              full_0_c,
  input  logic              full_1_c,
  output logic [DATA_W-1:0] data_out_0_c,
  output logic              valid_out_0_c,
  output logic [DATA_W-1:0] data_out_1_c,
  output logic              valid_out_1_c,
  output logic              drop_c,
  output logic [CNT_W-1:0]  count_0_c,
  output logic [CNT_W-1:0]  count_1_c
);

  typedef enum logic [3:0] {
    IDLE_NEXT0 = 4'b0001,
    IDLE_NEXT1 = 4'b0010,
    ROUTE_0    = 4'b0100,
    ROUTE_1    = 4'b1000
  } state_t;

  state_t state_q, state_d;

  logic lane_sel;
  logic full_sel;
  logic idle0_lane, idle1_lane;
  logic drop_d, drop_q;

  logic [DATA_W-1:0] data_d  [2];
  logic [DATA_W-1:0] data_q  [2];
  logic              valid_d [2];
  logic              valid_q [2];
  logic [CNT_W-1:0]  count_d [2];
  logic [CNT_W-1:0]  count_q [2];

`ifdef DEMUX_TAG_ROUTE_EN
  // Both idle states collapse to one: the first word's tag chooses the lane.
  assign idle0_lane = data_in_c[DATA_W-1];
  assign idle1_lane = data_in_c[DATA_W-1];
`else
  assign idle0_lane = 1'b0;
  assign idle1_lane = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE_NEXT0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_NEXT0: if (valid_in_c) state_d = lane_sel ? ROUTE_1 : ROUTE_0;
      IDLE_NEXT1: if (valid_in_c) state_d = lane_sel ? ROUTE_1 : ROUTE_0;
      ROUTE_0:    if (!valid_in_c) state_d = IDLE_NEXT1;
      ROUTE_1:    if (!valid_in_c) state_d = IDLE_NEXT0;
      default:    state_d = IDLE_NEXT0;
    endcase
  end

  // Destination lane of the word currently presented, and the fate of that word.
  always_comb begin
    lane_sel = 1'b0;
    case (state_q)
      IDLE_NEXT0: lane_sel = idle0_lane;
      IDLE_NEXT1: lane_sel = idle1_lane;
      ROUTE_0:    lane_sel = 1'b0;
      ROUTE_1:    lane_sel = 1'b1;
      default:    lane_sel = 1'b0;
    endcase
    full_sel = lane_sel ? full_1_c : full_0_c;
    drop_d   = valid_in_c & full_sel;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic hit;

      always_comb begin
        hit         = valid_in_c && !full_sel && (lane_sel == 1'(gi));
        valid_d[gi] = hit;
        data_d[gi]  = hit ? data_in_c : '0;
        count_d[gi] = count_q[gi] + {{(CNT_W-1){1'b0}}, hit};
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q[gi] <= 1'b0;
          data_q[gi]  <= '0;
          count_q[gi] <= '0;
        end else begin
          valid_q[gi] <= valid_d[gi];
          data_q[gi]  <= data_d[gi];
          count_q[gi] <= count_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign data_out_0_c  = data_q[0];
  assign valid_out_0_c = valid_q[0];
  assign data_out_1_c  = data_q[1];
  assign valid_out_1_c = valid_q[1];
  assign drop_c        = drop_q;
  assign count_0_c     = count_q[0];
  assign count_1_c     = count_q[1];

endmodule

// File: tb/tb_demux.sv
// Self-checking bench for demux: directed scenarios plus random traffic against a burst-level model.
// Build with DEMUX_TAG_ROUTE_EN defined to exercise tag routing.
module tb_demux;
  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in_c;
  logic          valid_in_c;
  logic          full_0_c;
  logic          full_1_c;
  logic [DW-1:0] data_out_0_c;
  logic          valid_out_0_c;
  logic [DW-1:0] data_out_1_c;
  logic          valid_out_1_c;
  logic          drop_c;
  logic [CW-1:0] count_0_c;
  logic [CW-1:0] count_1_c;

  demux #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .data_in_c(data_in_c), .valid_in_c(valid_in_c),
    .full_0_c(full_0_c), .full_1_c(full_1_c),
    .data_out_0_c(data_out_0_c), .valid_out_0_c(valid_out_0_c),
    .data_out_1_c(data_out_1_c), .valid_out_1_c(valid_out_1_c),
    .drop_c(drop_c), .count_0_c(count_0_c), .count_1_c(count_1_c)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Burst-level model: bursts are numbered; lane = burst number parity (or first-word tag).
  int burst_n  = 0;
  bit in_burst = 0;
  int cur_lane = 0;
  int m_cnt [2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit v, input logic [DW-1:0] d, input bit f0, input bit f1);
    logic          e_v [2];
    logic [DW-1:0] e_d [2];
    logic          e_drop;
    bit            full;
    e_v = '{1'b0, 1'b0};
    e_d = '{'0, '0};
    e_drop = 1'b0;
    reset = rst; valid_in_c = v; data_in_c = d; full_0_c = f0; full_1_c = f1;
    if (rst) begin
      burst_n = 0; in_burst = 0; m_cnt = '{0, 0};
    end else if (v) begin
      if (!in_burst) begin
`ifdef DEMUX_TAG_ROUTE_EN
        cur_lane = int'(d[DW-1]);
`else
        cur_lane = burst_n % 2;
`endif
        burst_n++;
        in_burst = 1;
      end
      full = (cur_lane == 1) ? f1 : f0;
      if (full) begin
        e_drop = 1'b1;
      end else begin
        m_cnt[cur_lane] = (m_cnt[cur_lane] + 1) % (1 << CW);
        e_v[cur_lane] = 1'b1;
        e_d[cur_lane] = d;
      end
    end else begin
      in_burst = 0;
    end
    @(posedge clk); #1;
    chk("valid0", 32'(valid_out_0_c), 32'(e_v[0]));
    chk("data0",  32'(data_out_0_c),  32'(e_d[0]));
    chk("valid1", 32'(valid_out_1_c), 32'(e_v[1]));
    chk("data1",  32'(data_out_1_c),  32'(e_d[1]));
    chk("drop",   32'(drop_c),        32'(e_drop));
    chk("count0", 32'(count_0_c),     32'(m_cnt[0]));
    chk("count1", 32'(count_1_c),     32'(m_cnt[1]));
    $display("t=%0t rst=%0d v=%0d d=%02h f=%0d%0d -> v0=%0d d0=%02h v1=%0d d1=%02h drop=%0d c0=%0d c1=%0d",
             $time, rst, v, d, f0, f1, valid_out_0_c, data_out_0_c, valid_out_1_c, data_out_1_c,
             drop_c, count_0_c, count_1_c);
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
  endtask

  initial begin
    reset = 1'b1; valid_in_c = 1'b0; data_in_c = '0; full_0_c = 1'b0; full_1_c = 1'b0;

    // Reset state
    do_reset();
    chk("rst_v0", 32'(valid_out_0_c), 32'd0);
    chk("rst_c0", 32'(count_0_c), 32'd0);

    // Single three-word burst to lane 0
    step(0, 1, 8'h11, 0, 0);
    step(0, 1, 8'h22, 0, 0);
    step(0, 1, 8'h33, 0, 0);
    idle();
    chk("burst1_c0", 32'(count_0_c), 32'd3);
    chk("burst1_c1", 32'(count_1_c), 32'd0);

    // Alternating bursts separated by single gaps
    do_reset();
    step(0, 1, 8'hA0, 0, 0);
    step(0, 1, 8'hA1, 0, 0);
    idle();
    step(0, 1, 8'hB0, 0, 0);
    idle();
    step(0, 1, 8'hC0, 0, 0);
    idle();
`ifndef DEMUX_TAG_ROUTE_EN
    chk("alt_c0", 32'(count_0_c), 32'd3);
    chk("alt_c1", 32'(count_1_c), 32'd1);
`endif

    // Mid-burst full drops one word; other lane's full is ignored
    do_reset();
    step(0, 1, 8'h01, 0, 1);
    step(0, 1, 8'h02, 1, 0);
    chk("bp_drop_pulse", 32'(drop_c), 32'd1);
    step(0, 1, 8'h03, 0, 1);
    chk("bp_drop_clear", 32'(drop_c), 32'd0);
    idle();
    chk("bp_c0", 32'(count_0_c), 32'd2);

    // Reset in the middle of a burst
    do_reset();
    step(0, 1, 8'h44, 0, 0);
    step(1, 1, 8'h55, 0, 0);
    chk("midrst_v0", 32'(valid_out_0_c), 32'd0);
    chk("midrst_c0", 32'(count_0_c), 32'd0);
    step(0, 1, 8'h66, 0, 0);
    step(0, 1, 8'h77, 0, 0);
    idle();
    chk("midrst_after_c0", 32'(count_0_c), 32'd2);
    chk("midrst_after_c1", 32'(count_1_c), 32'd0);

    // 256 single-word bursts, then a 128-word lane-0 burst to wrap count_0
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [DW-1:0] w;
      w = {1'(i % 2), 7'($urandom)};
      step(0, 1, w, 0, 0);
      idle();
    end
    chk("many_c0", 32'(count_0_c), 32'd128);
    chk("many_c1", 32'(count_1_c), 32'd128);
    for (int i = 0; i < 128; i++) begin
      step(0, 1, {1'b0, 7'($urandom)}, 0, 0);
    end
    idle();
    chk("wrap_c0", 32'(count_0_c), 32'd0);
    chk("wrap_c1", 32'(count_1_c), 32'd128);

`ifdef DEMUX_TAG_ROUTE_EN
    // Tag bit of the first word steers the whole burst
    do_reset();
    step(0, 1, 8'h85, 0, 0);
    chk("tag_first_v1", 32'(valid_out_1_c), 32'd1);
    step(0, 1, 8'h05, 0, 0);
    chk("tag_follow_d1", 32'(data_out_1_c), 32'h05);
    idle();
    step(0, 1, 8'h07, 0, 0);
    chk("tag_lane0_d0", 32'(data_out_0_c), 32'h07);
    idle();
    chk("tag_c0", 32'(count_0_c), 32'd1);
    chk("tag_c1", 32'(count_1_c), 32'd2);
`endif

    // Random traffic with occasional backpressure and resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, 8'($urandom),
           $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
